// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, issues single-outstanding imem
// requests and buffers returned words in a small FIFO toward decode.
//   state   | meaning
//   S_IDLE  | one cycle after reset release
//   S_FETCH | request pending at pc_reg
//   S_FULL  | FIFO full, no request
//   S_DROP  | waiting to absorb ack of an abandoned request
//   S_HALT  | stopped on a misaligned target
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] next_pc_in,
  input  logic        redirect_in,
  input  logic        misaligned_instr_in,
  output logic [31:0] pc_out,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        misaligned_out
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FULL, S_DROP, S_HALT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc_reg, pc_nxt;
  logic          halt_pend, halt_pend_nxt;
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_data [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop, flush, pending;

  always_comb begin
    pending = (state == S_FETCH) || (state == S_DROP) || ((state == S_HALT) && halt_pend);
    flush   = redirect_in;
    pop     = (count != '0) && instr_ready_in;
    push    = (state == S_FETCH) && imem_ack_in && !redirect_in && ((count < QFULL) || pop);

    count_nxt = count;
    if (flush)              count_nxt = '0;
    else if (push && !pop)  count_nxt = count + CW'(1);
    else if (pop && !push)  count_nxt = count - CW'(1);

    state_nxt     = state;
    pc_nxt        = pc_reg;
    halt_pend_nxt = halt_pend;
    if (redirect_in) begin
      pc_nxt = next_pc_in;
      if (misaligned_instr_in) begin
        state_nxt     = S_HALT;
        halt_pend_nxt = pending && !imem_ack_in;
      end else if (pending && !imem_ack_in) begin
        state_nxt     = S_DROP;
        halt_pend_nxt = 1'b0;
      end else begin
        state_nxt     = S_FETCH;
        halt_pend_nxt = 1'b0;
      end
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_FETCH;
        S_FETCH: begin
          if (push) begin
            pc_nxt = next_pc_in;
            if (count_nxt == QFULL) state_nxt = S_FULL;
          end
        end
        S_FULL:  if (pop) state_nxt = S_FETCH;
        S_DROP:  if (imem_ack_in) state_nxt = S_FETCH;
        S_HALT:  if (halt_pend && imem_ack_in) halt_pend_nxt = 1'b0;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      pc_reg    <= RESET_PC;
      halt_pend <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      pc_reg    <= pc_nxt;
      halt_pend <= halt_pend_nxt;
      count     <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          q_pc[wr_ptr]   <= pc_reg;
          q_data[wr_ptr] <= imem_rdata_in;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  assign pc_out          = pc_reg;
  assign imem_req_out    = (state == S_FETCH);
  assign imem_addr_out   = pc_reg;
  assign instr_valid_out = (count != '0);
  assign instr_out       = instr_valid_out ? q_data[rd_ptr] : '0;
  assign instr_pc_out    = instr_valid_out ? q_pc[rd_ptr] : '0;
  assign misaligned_out  = (state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; bench models pc_unit (pc+4 or redirect target)
// and an imem whose word is {16'hC0DE, addr[15:0]}.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc, target;
  logic        redir, mis;
  logic [31:0] pc_out, addr, rdata, instr, instr_pc;
  logic        req, ack, valid, ready, misal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign next_pc = redir ? target : pc_out + 32'd4;
  assign rdata   = {16'hC0DE, addr[15:0]};

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk_in(clk), .rst_in(rst), .next_pc_in(next_pc), .redirect_in(redir),
    .misaligned_instr_in(mis), .pc_out(pc_out), .imem_req_out(req),
    .imem_addr_out(addr), .imem_ack_in(ack), .imem_rdata_in(rdata),
    .instr_valid_out(valid), .instr_ready_in(ready), .instr_out(instr),
    .instr_pc_out(instr_pc), .misaligned_out(misal)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ack = 1'b0; redir = 1'b0; mis = 1'b0; ready = 1'b0; target = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ack = 1'b0; redir = 1'b0; mis = 1'b0; ready = 1'b0; target = '0;
    @(negedge clk);
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", req); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc got=%0h exp=0", pc_out); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", valid); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL rst_head got=%0h/%0h exp=0/0", instr, instr_pc); end
    checks++; if (misal !== 1'b0) begin failures++; $display("FAIL rst_misal got=%0h exp=0", misal); end
    rst = 1'b0;
    #1;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL idle_req got=%0h exp=0", req); end
    @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== 32'h0) begin failures++; $display("FAIL first_req got=%0h@%0h exp=1@0", req, addr); end
  endtask

  task automatic test_stream();
    do_reset();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL stream_pre_valid got=%0h exp=0", valid); end
    ack = 1'b1; ready = 1'b1;
    @(negedge clk);
    checks++; if (valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hC0DE0000) begin
      failures++; $display("FAIL stream_0 got=%0h %0h %0h exp=1 0 c0de0000", valid, instr_pc, instr); end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      checks++; if (valid !== 1'b1 || instr_pc !== 32'(4*k) || instr !== (32'hC0DE0000 | 32'(4*k))) begin
        failures++; $display("FAIL stream_%0d got=%0h %0h %0h exp=1 %0h %0h", k, valid, instr_pc, instr, 4*k, 32'hC0DE0000 | 32'(4*k)); end
    end
    ack = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h10) begin
      failures++; $display("FAIL stream_drain got=%0h %0h %0h exp=0 1 10", valid, req, addr); end
  endtask

  task automatic test_full();
    do_reset();
    ack = 1'b1; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (req !== 1'b0 || valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hC0DE0000) begin
      failures++; $display("FAIL full_enter got=%0h %0h %0h %0h exp=0 1 0 c0de0000", req, valid, instr_pc, instr); end
    ack = 1'b0;
    @(negedge clk);
    checks++; if (req !== 1'b0 || instr_pc !== 32'h0 || instr !== 32'hC0DE0000) begin
      failures++; $display("FAIL full_hold got=%0h %0h %0h exp=0 0 c0de0000", req, instr_pc, instr); end
    ready = 1'b1;
    @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== 32'h8 || instr_pc !== 32'h4) begin
      failures++; $display("FAIL full_resume got=%0h %0h %0h exp=1 8 4", req, addr, instr_pc); end
    ready = 1'b0;
  endtask

  task automatic test_redirect_drop();
    do_reset();
    ready = 1'b1; redir = 1'b1; target = 32'h100;
    @(negedge clk);
    redir = 1'b0;
    checks++; if (req !== 1'b0 || pc_out !== 32'h100 || valid !== 1'b0) begin
      failures++; $display("FAIL drop_enter got=%0h %0h %0h exp=0 100 0", req, pc_out, valid); end
    @(negedge clk);
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL drop_wait got=%0h exp=0", req); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h100) begin
      failures++; $display("FAIL drop_exit got=%0h %0h %0h exp=0 1 100", valid, req, addr); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'hC0DE0100) begin
      failures++; $display("FAIL drop_new got=%0h %0h %0h exp=1 100 c0de0100", valid, instr_pc, instr); end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    ack = 1'b1; redir = 1'b1; target = 32'h40;
    @(negedge clk);
    redir = 1'b0; ack = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h40) begin
      failures++; $display("FAIL redir_ack got=%0h %0h %0h exp=0 1 40", valid, req, addr); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b1 || instr_pc !== 32'h40) begin
      failures++; $display("FAIL flush_pre got=%0h %0h exp=1 40", valid, instr_pc); end
    ready = 1'b1; redir = 1'b1; target = 32'h80;
    @(negedge clk);
    redir = 1'b0; ready = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b0 || pc_out !== 32'h80) begin
      failures++; $display("FAIL flush_post got=%0h %0h %0h exp=0 0 80", valid, req, pc_out); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h80) begin
      failures++; $display("FAIL flush_resume got=%0h %0h %0h exp=0 1 80", valid, req, addr); end
  endtask

  task automatic test_misaligned();
    do_reset();
    redir = 1'b1; mis = 1'b1; target = 32'h102;
    @(negedge clk);
    redir = 1'b0; mis = 1'b0;
    checks++; if (misal !== 1'b1 || req !== 1'b0 || valid !== 1'b0) begin
      failures++; $display("FAIL halt_enter got=%0h %0h %0h exp=1 0 0", misal, req, valid); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (misal !== 1'b1 || req !== 1'b0 || valid !== 1'b0) begin
      failures++; $display("FAIL halt_absorb got=%0h %0h %0h exp=1 0 0", misal, req, valid); end
    redir = 1'b1; target = 32'h200;
    @(negedge clk);
    redir = 1'b0;
    checks++; if (misal !== 1'b0 || req !== 1'b1 || addr !== 32'h200) begin
      failures++; $display("FAIL halt_exit got=%0h %0h %0h exp=0 1 200", misal, req, addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ack = 1'b1; ready = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b1 || req !== 1'b1 || addr !== 32'h4) begin
      failures++; $display("FAIL mid_pre got=%0h %0h %0h exp=1 1 4", valid, req, addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || req !== 1'b0 || pc_out !== 32'h0) begin
      failures++; $display("FAIL mid_rst got=%0h %0h %0h exp=0 0 0", valid, req, pc_out); end
    ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h0) begin
      failures++; $display("FAIL mid_late_ack got=%0h %0h %0h exp=0 1 0", valid, req, addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_flush();
    test_misaligned();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
